// File: rtl/bp_pkg.sv
// Types shared by the branch predictor and its training-side resolve queue.
// Default PC width and the queued branch record live here.
package bp_pkg;

    localparam int BP_XLEN = 32;

    typedef struct packed {
        logic               pred;
        logic [BP_XLEN-1:0] alt_pc;
    } brq_entry_t;

endpackage

// File: rtl/brq_fifo.sv
// Circular buffer of branch records with push/pop, flush-clear and squash.
// Registered pointers/count; head is a combinational read of the oldest entry.
module brq_fifo
    import bp_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTRW  = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_en,
    input  logic            i_clear,
    input  logic            i_squash,
    input  logic            i_push,
    input  logic            i_pop,
    input  brq_entry_t      i_push_dat,
    output brq_entry_t      o_head_dat,
    output logic [PTRW:0]   o_count,
    output logic            o_full
);

    brq_entry_t        r_mem [DEPTH];
    logic [PTRW-1:0]   r_rd_ptr;
    logic [PTRW-1:0]   r_wr_ptr;
    logic [PTRW:0]     r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (i_en) begin
            if (i_clear) begin
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
                r_count  <= '0;
            end else if (i_squash) begin
                // Head is consumed by the mispredict; everything younger is wrong-path.
                r_rd_ptr <= r_rd_ptr + 1'b1;
                r_wr_ptr <= r_rd_ptr + 1'b1;
                r_count  <= '0;
            end else begin
                if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
                if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
                r_count <= r_count + (PTRW+1)'(i_push) - (PTRW+1)'(i_pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (i_en && i_push && !i_clear && !i_squash) begin
            r_mem[r_wr_ptr] <= i_push_dat;
        end
    end

    assign o_head_dat = r_mem[r_rd_ptr];
    assign o_count    = r_count;
    assign o_full     = (r_count == (PTRW+1)'(DEPTH));

endmodule

// File: rtl/branch_resolve_queue.sv
// Queues fetched branch predictions, compares against execute outcomes, trains the predictor, redirects fetch.
// One-cycle registered outputs; push_ready drops when full. Optional counters under BRQ_STATS_EN.
module branch_resolve_queue
    import bp_pkg::*;
#(
    parameter  int DEPTH = 4,
    parameter  int XLEN  = BP_XLEN,
    localparam int PTRW  = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clk_en,
    input  logic             flush,
    input  logic             push_valid,
    output logic             push_ready,
    input  logic             push_pred,
    input  logic [XLEN-1:0]  push_alt_pc,
    input  logic             resolve_valid,
    input  logic             resolve_taken,
    output logic             feedback_enable,
    output logic             actual_result,
    output logic             mispredict,
    output logic [XLEN-1:0]  redirect_pc,
    output logic [PTRW:0]    occupancy,
    output logic             resolve_err
`ifdef BRQ_STATS_EN
    ,
    output logic [31:0]      stat_resolved,
    output logic [31:0]      stat_mispred
`endif
);

    brq_entry_t      w_head;
    brq_entry_t      w_push_entry;
    logic [PTRW:0]   w_count;
    logic            w_full;
    logic            w_empty;
    logic            w_resolve_hit;
    logic            w_mis;
    logic            w_pop;
    logic            w_push;

    logic            r_fb;
    logic            r_act;
    logic            r_mis;
    logic            r_err;
    logic [XLEN-1:0] r_redir;

    assign w_empty       = (w_count == '0);
    assign w_resolve_hit = resolve_valid && !w_empty && !flush;
    assign w_mis         = w_resolve_hit && (resolve_taken != w_head.pred);
    assign w_pop         = w_resolve_hit && !w_mis;
    // Readiness is taken from the pre-edge count, so a pop while full never makes room this cycle.
    assign w_push        = push_valid && !w_full && !flush && !w_mis;
    assign w_push_entry  = '{pred: push_pred, alt_pc: push_alt_pc};

    brq_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_en       (clk_en),
        .i_clear    (flush),
        .i_squash   (w_mis),
        .i_push     (w_push),
        .i_pop      (w_pop),
        .i_push_dat (w_push_entry),
        .o_head_dat (w_head),
        .o_count    (w_count),
        .o_full     (w_full)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fb    <= 1'b0;
            r_act   <= 1'b0;
            r_mis   <= 1'b0;
            r_err   <= 1'b0;
            r_redir <= '0;
        end else if (clk_en) begin
            r_fb  <= w_resolve_hit;
            r_mis <= w_mis;
            r_err <= resolve_valid && w_empty && !flush;
            if (w_resolve_hit) r_act   <= resolve_taken;
            if (w_mis)         r_redir <= w_head.alt_pc;
        end
    end

    assign push_ready      = !w_full;
    assign occupancy       = w_count;
    assign feedback_enable = r_fb;
    assign actual_result   = r_act;
    assign mispredict      = r_mis;
    assign redirect_pc     = r_redir;
    assign resolve_err     = r_err;

`ifdef BRQ_STATS_EN
    logic [31:0] r_stat_resolved;
    logic [31:0] r_stat_mispred;

    // Counters advance on the same edge that raises their pulse; they saturate rather than wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_resolved <= '0;
            r_stat_mispred  <= '0;
        end else if (clk_en) begin
            if (w_resolve_hit && (r_stat_resolved != 32'hFFFF_FFFF))
                r_stat_resolved <= r_stat_resolved + 32'd1;
            if (w_mis && (r_stat_mispred != 32'hFFFF_FFFF))
                r_stat_mispred <= r_stat_mispred + 32'd1;
        end
    end

    assign stat_resolved = r_stat_resolved;
    assign stat_mispred  = r_stat_mispred;
`endif

endmodule
